// File: rtl/hdlc_pkg.sv
// Shared constants and FSM encoding for the HDLC receive buffer
// read-out path (512x8 RAM, length words at the top two addresses).
package hdlc_pkg;

  localparam int RAM_AW = 9;
  localparam int RAM_DW = 8;

  localparam logic [RAM_AW-1:0] ADDR_LEN_LO_DEF = 9'd510;
  localparam logic [RAM_AW-1:0] ADDR_LEN_HI_DEF = 9'd511;
  localparam logic [RAM_AW-1:0] MAX_LEN_DEF     = 9'd510;
  localparam logic [RAM_AW-1:0] CRC_BYTES_DEF   = 9'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_CHECK = 3'd3,
    ST_RD    = 3'd4,
    ST_RDW   = 3'd5,
    ST_OUT   = 3'd6,
    ST_DONE  = 3'd7
  } rd_state_e;

endpackage

// File: rtl/hdlc_sync_edge.sv
// Two-flop synchronizer plus registered rising-edge pulse for a slow
// strobe crossing into the local clock domain.
module hdlc_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);

  logic [2:0] sync_q;
  logic       rise_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], async_i};
      rise_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/hdlc_rx_rdctl.sv
// HDLC receive buffer read-out: length fetch, validation, byte streaming.
// Define HDLC_RXC_CRC_STRIP_EN to drop the trailing FCS bytes.
module hdlc_rx_rdctl
  import hdlc_pkg::*;
#(
  parameter logic [RAM_AW-1:0] ADDR_LEN_LO = ADDR_LEN_LO_DEF,
  parameter logic [RAM_AW-1:0] ADDR_LEN_HI = ADDR_LEN_HI_DEF,
  parameter logic [RAM_AW-1:0] MAX_LEN     = MAX_LEN_DEF,
  parameter logic [RAM_AW-1:0] CRC_BYTES   = CRC_BYTES_DEF
) (
  input  logic              clk_100m,
  input  logic              rst,
  input  logic              rx_irq,
  output logic              ram_rd_en,
  output logic [RAM_AW-1:0] ram_rd_addr,
  input  logic [RAM_DW-1:0] ram_rd_data,
  output logic [RAM_DW-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic [RAM_AW-1:0] frame_len,
  output logic              frame_done,
  output logic              frame_err,
  output logic              irq_overrun,
  output logic              busy
);

  rd_state_e         state_q, state_d;
  logic [RAM_DW-1:0] len_lo_q, len_lo_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [RAM_AW-1:0] flen_q, flen_d;
  logic [RAM_DW-1:0] mdat_q, mdat_d;
  logic              mval_q, mval_d;
  logic              mlast_q, mlast_d;

  logic              irq_rise;
  logic              rd_en;
  logic [RAM_AW-1:0] rd_addr;
  logic              err_p;
  logic              done_p;
  logic [RAM_AW-1:0] len_full;
  logic [RAM_AW-1:0] out_len;
  logic              len_bad;

  hdlc_sync_edge u_sync (
    .clk_i   (clk_100m),
    .rst_i   (rst),
    .async_i (rx_irq),
    .rise_o  (irq_rise)
  );

  // Length high word arrives in CHECK, so it is used straight off the bus.
  assign len_full = {ram_rd_data[0], len_lo_q};

`ifdef HDLC_RXC_CRC_STRIP_EN
  assign out_len = len_full - CRC_BYTES;
  assign len_bad = (len_full <= CRC_BYTES) || (len_full > MAX_LEN);
`else
  assign out_len = len_full;
  assign len_bad = (len_full == '0) || (len_full > MAX_LEN);
`endif

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      len_lo_q <= '0;
      addr_q   <= '0;
      flen_q   <= '0;
      mdat_q   <= '0;
      mval_q   <= 1'b0;
      mlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      addr_q   <= addr_d;
      flen_q   <= flen_d;
      mdat_q   <= mdat_d;
      mval_q   <= mval_d;
      mlast_q  <= mlast_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    addr_d   = addr_q;
    flen_d   = flen_q;
    mdat_d   = mdat_q;
    mval_d   = mval_q;
    mlast_d  = mlast_q;
    rd_en    = 1'b0;
    rd_addr  = addr_q;
    err_p    = 1'b0;
    done_p   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (irq_rise) state_d = ST_LEN0;
      end
      ST_LEN0: begin
        rd_en   = 1'b1;
        rd_addr = ADDR_LEN_LO;
        state_d = ST_LEN1;
      end
      ST_LEN1: begin
        rd_en    = 1'b1;
        rd_addr  = ADDR_LEN_HI;
        len_lo_d = ram_rd_data;
        state_d  = ST_CHECK;
      end
      ST_CHECK: begin
        if (len_bad) begin
          err_p   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          flen_d  = out_len;
          addr_d  = '0;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        rd_en   = 1'b1;
        state_d = ST_RDW;
      end
      ST_RDW: begin
        mdat_d  = ram_rd_data;
        mval_d  = 1'b1;
        mlast_d = (addr_q == flen_q - 9'd1);
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (m_ready) begin
          mval_d  = 1'b0;
          mlast_d = 1'b0;
          if (mlast_q) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + 9'd1;
            state_d = ST_RD;
          end
        end
      end
      ST_DONE: begin
        done_p  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ram_rd_en   = rd_en;
  assign ram_rd_addr = rd_addr;
  assign m_data      = mdat_q;
  assign m_valid     = mval_q;
  assign m_last      = mlast_q;
  assign frame_len   = flen_q;
  assign frame_done  = done_p;
  assign frame_err   = err_p;
  assign irq_overrun = irq_rise && (state_q != ST_IDLE);
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hdlc_rx_rdctl.sv
// Directed bench for hdlc_rx_rdctl with a behavioural 512x8 RAM.
// Expected stream length follows HDLC_RXC_CRC_STRIP_EN.
module tb_hdlc_rx_rdctl;

`ifdef HDLC_RXC_CRC_STRIP_EN
  localparam int STRIP = 2;
`else
  localparam int STRIP = 0;
`endif

  logic       clk_100m = 1'b0;
  logic       rst = 1'b1;
  logic       rx_irq = 1'b0;
  logic       ram_rd_en;
  logic [8:0] ram_rd_addr;
  logic [7:0] ram_rd_data = 8'h00;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready = 1'b1;
  logic [8:0] frame_len;
  logic       frame_done;
  logic       frame_err;
  logic       irq_overrun;
  logic       busy;

  always #5 clk_100m = ~clk_100m;

  hdlc_rx_rdctl dut (
    .clk_100m    (clk_100m),
    .rst         (rst),
    .rx_irq      (rx_irq),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_last      (m_last),
    .m_ready     (m_ready),
    .frame_len   (frame_len),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .irq_overrun (irq_overrun),
    .busy        (busy)
  );

  logic [7:0] mem [512];

  always @(posedge clk_100m)
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];

  int checks = 0;
  int failures = 0;
  int rdy_mode = 0;
  int cyc = 0;

  // m_ready changes just after the rising edge
  initial begin
    forever begin
      @(posedge clk_100m);
      #1;
      cyc = cyc + 1;
      case (rdy_mode)
        1: m_ready = ((cyc % 4) == 0);
        2: m_ready = 1'b0;
        default: m_ready = 1'b1;
      endcase
    end
  end

  int n_done = 0, n_err = 0, n_ovr = 0;
  int n_vcyc = 0, n_drd = 0, n_stall_bad = 0;
  logic [7:0] got_d [$];
  logic       got_l [$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  always @(negedge clk_100m) begin
    if (frame_done) n_done = n_done + 1;
    if (frame_err) n_err = n_err + 1;
    if (irq_overrun) n_ovr = n_ovr + 1;
    if (m_valid) n_vcyc = n_vcyc + 1;
    if (ram_rd_en && ram_rd_addr < 9'd510) n_drd = n_drd + 1;
    if (m_valid && m_ready) begin
      got_d.push_back(m_data);
      got_l.push_back(m_last);
    end
    if (prev_stall && m_valid &&
        (m_data !== prev_data || m_last !== prev_last))
      n_stall_bad = n_stall_bad + 1;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
  end

  function automatic logic [7:0] fdat(input int kind, input int i);
    logic [31:0] v;
    case (kind)
      0: v = 32'hA0 + i;
      1: v = (i & 255) ^ ((i >= 256) ? 32'h55 : 32'h0);
      default: v = 32'h30 + i * 7;
    endcase
    return v[7:0];
  endfunction

  task automatic load(input int len, input int kind);
    logic [31:0] l;
    l = len;
    for (int i = 0; i < 510; i++) mem[i] = fdat(kind, i);
    mem[510] = l[7:0];
    mem[511] = {7'b0, l[8]};
  endtask

  task automatic pulse_irq();
    @(posedge clk_100m);
    #1 rx_irq = 1'b1;
    repeat (4) @(posedge clk_100m);
    #1 rx_irq = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk_100m);
      if (busy) seen = 1'b1;
      else if (seen) break;
    end
    checks++;
    if (!(seen && !busy)) begin
      failures++;
      $display("FAIL %s idle_timeout: seen_busy=%0b busy=%0b required 1/0",
               nm, seen, busy);
    end
  endtask

  task automatic wait_valid(input string nm);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_100m);
      if (m_valid) break;
    end
    checks++;
    if (m_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s valid_timeout: m_valid=%0b required 1", nm, m_valid);
    end
  endtask

  task automatic run_frame(input string nm, input int len, input int kind,
                           input bit second_irq);
    int s0, d0, e0, exp_n, cnt, nbad, first_bad;
    exp_n = len - STRIP;
    s0 = got_d.size();
    d0 = n_done;
    e0 = n_err;
    pulse_irq();
    if (second_irq) begin
      wait_valid(nm);
      pulse_irq();
    end
    wait_idle(nm);
    cnt = got_d.size() - s0;
    checks++;
    if (cnt !== exp_n) begin
      failures++;
      $display("FAIL %s byte_count: got %0d required %0d", nm, cnt, exp_n);
    end
    nbad = 0;
    first_bad = -1;
    for (int i = 0; i < cnt && i < exp_n; i++) begin
      if (got_d[s0+i] !== fdat(kind, i) ||
          got_l[s0+i] !== (i == exp_n - 1)) begin
        nbad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    checks++;
    if (nbad != 0) begin
      failures++;
      $display("FAIL %s data_last: %0d bad bytes, first at %0d got %h/%0b required %h",
               nm, nbad, first_bad, got_d[s0+first_bad], got_l[s0+first_bad],
               fdat(kind, first_bad));
    end
    checks++;
    if (frame_len !== 9'(exp_n)) begin
      failures++;
      $display("FAIL %s frame_len: got %0d required %0d", nm, frame_len, exp_n);
    end
    checks++;
    if (n_done - d0 != 1 || n_err - e0 != 0) begin
      failures++;
      $display("FAIL %s pulses: done=%0d err=%0d required 1/0",
               nm, n_done - d0, n_err - e0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk_100m);
    @(negedge clk_100m);
    checks++;
    if ({m_valid, m_last, m_data, frame_len, frame_done, frame_err,
         irq_overrun, busy, ram_rd_en, ram_rd_addr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%0b last=%0b data=%h len=%0d done=%0b err=%0b ovr=%0b busy=%0b rden=%0b addr=%0d required all 0",
               m_valid, m_last, m_data, frame_len, frame_done, frame_err,
               irq_overrun, busy, ram_rd_en, ram_rd_addr);
    end
    @(posedge clk_100m);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk_100m);
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: busy=%0b m_valid=%0b required 0/0",
               busy, m_valid);
    end
  endtask

  task automatic test_basic();
    load(12, 0);
    run_frame("basic", 12, 0, 1'b0);
  endtask

  task automatic test_len300();
    load(300, 1);
    run_frame("len300", 300, 1, 1'b0);
  endtask

  task automatic test_bad_len();
    int lens [2];
    int e0, v0, r0, d0;
    logic [8:0] prev_len;
    lens[0] = (STRIP == 2) ? 2 : 0;
    lens[1] = 511;
    for (int t = 0; t < 2; t++) begin
      prev_len = frame_len;
      load(lens[t], 0);
      e0 = n_err; v0 = n_vcyc; r0 = n_drd; d0 = n_done;
      pulse_irq();
      wait_idle("bad_len");
      repeat (4) @(negedge clk_100m);
      checks++;
      if (n_err - e0 != 1) begin
        failures++;
        $display("FAIL bad_len_%0d err_pulses: got %0d required 1",
                 lens[t], n_err - e0);
      end
      checks++;
      if (n_vcyc - v0 != 0 || n_drd - r0 != 0 || n_done - d0 != 0) begin
        failures++;
        $display("FAIL bad_len_%0d activity: valid=%0d reads=%0d done=%0d required 0",
                 lens[t], n_vcyc - v0, n_drd - r0, n_done - d0);
      end
      checks++;
      if (frame_len !== prev_len) begin
        failures++;
        $display("FAIL bad_len_%0d frame_len: got %0d required %0d",
                 lens[t], frame_len, prev_len);
      end
    end
  endtask

  task automatic test_backpressure();
    int sb0;
    sb0 = n_stall_bad;
    rdy_mode = 1;
    load(6, 2);
    run_frame("backpressure", 6, 2, 1'b0);
    rdy_mode = 0;
    checks++;
    if (n_stall_bad - sb0 != 0) begin
      failures++;
      $display("FAIL backpressure stall_stable: %0d changes required 0",
               n_stall_bad - sb0);
    end
  endtask

  task automatic test_overrun();
    int o0, bc;
    o0 = n_ovr;
    load(12, 0);
    run_frame("overrun", 12, 0, 1'b1);
    bc = 0;
    repeat (20) begin
      @(negedge clk_100m);
      if (busy) bc++;
    end
    checks++;
    if (n_ovr - o0 != 1) begin
      failures++;
      $display("FAIL overrun pulses: got %0d required 1", n_ovr - o0);
    end
    checks++;
    if (bc != 0) begin
      failures++;
      $display("FAIL overrun no_restart: busy cycles %0d required 0", bc);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = n_done;
    rdy_mode = 2;
    load(12, 0);
    pulse_irq();
    wait_valid("reset_mid");
    @(posedge clk_100m);
    #1 rst = 1'b1;
    @(posedge clk_100m);
    #1 rst = 1'b0;
    @(negedge clk_100m);
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid state: busy=%0b valid=%0b last=%0b required 0",
               busy, m_valid, m_last);
    end
    checks++;
    if (n_done - d0 != 0) begin
      failures++;
      $display("FAIL reset_mid done: got %0d required 0", n_done - d0);
    end
    rdy_mode = 0;
    repeat (5) @(posedge clk_100m);
    load(12, 2);
    run_frame("after_reset", 12, 2, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    test_reset();
    test_basic();
    test_len300();
    test_bad_len();
    test_backpressure();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
